// File: rtl/vpe_feature_arbiter.sv
// Round-robin arbiter sharing one VPE inference kernel between NUM_REQ feature requesters.
// Handles the kernel fetch/result handshake, tags results with the requester ID, and recovers via a watchdog.
module vpe_feature_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 256,
  parameter int TIMEOUT = 4096,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic                      k_fetch,
  output logic                      k_feature_valid,
  output logic [DATA_W-1:0]         k_feature,
  input  logic                      k_result_valid,
  input  logic [DATA_W-1:0]         k_result,
  output logic                      res_valid,
  input  logic                      res_ready,
  output logic [DATA_W-1:0]         res_data,
  output logic [ID_W-1:0]           res_id,
  output logic                      busy,
  output logic                      timeout_err,
  output logic [7:0]                err_count
);
  localparam int WD_W = $clog2(TIMEOUT) + 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_RUN  = 2'd2,
    S_RESP = 2'd3
  } state_e;

  state_e              state_q, state_d;
  logic [ID_W-1:0]     rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0]     cur_id_q, cur_id_d;
  logic [ID_W-1:0]     res_id_q, res_id_d;
  logic [DATA_W-1:0]   feat_buf_q, feat_buf_d;
  logic [DATA_W-1:0]   k_feature_q, k_feature_d;
  logic [DATA_W-1:0]   res_data_q, res_data_d;
  logic                k_feature_valid_q, k_feature_valid_d;
  logic                res_valid_q, res_valid_d;
  logic                timeout_err_q, timeout_err_d;
  logic [7:0]          err_count_q, err_count_d;
  logic [WD_W-1:0]     wd_q, wd_d;

  logic [NUM_REQ-1:0]  grant_s;
  logic [ID_W-1:0]     grant_id_s;
  logic                grant_any_s;
  logic [DATA_W-1:0]   grant_data_s;
  logic [ID_W:0]       cand_sum_s;
  logic [ID_W-1:0]     cand_id_s;
  logic [ID_W:0]       next_sum_s;
  logic [ID_W-1:0]     next_ptr_s;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    if (v == 8'hFF) begin
      return v;
    end else begin
      return v + 8'd1;
    end
  endfunction

  // Round-robin search starting at rr_ptr_q; first valid requester wins.
  always_comb begin
    grant_s      = '0;
    grant_id_s   = '0;
    grant_any_s  = 1'b0;
    grant_data_s = '0;
    cand_sum_s   = '0;
    cand_id_s    = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand_sum_s = {1'b0, rr_ptr_q} + (ID_W+1)'(k);
      if (cand_sum_s >= (ID_W+1)'(NUM_REQ)) begin
        cand_sum_s = cand_sum_s - (ID_W+1)'(NUM_REQ);
      end else begin
        cand_sum_s = cand_sum_s;
      end
      cand_id_s = cand_sum_s[ID_W-1:0];
      if (!grant_any_s && req_valid[cand_id_s]) begin
        grant_any_s          = 1'b1;
        grant_id_s           = cand_id_s;
        grant_s[cand_id_s]   = 1'b1;
        grant_data_s         = req_data[int'(cand_id_s)*DATA_W +: DATA_W];
      end else begin
        grant_any_s = grant_any_s;
      end
    end
    next_sum_s = {1'b0, grant_id_s} + {{ID_W{1'b0}}, 1'b1};
    if (next_sum_s >= (ID_W+1)'(NUM_REQ)) begin
      next_ptr_s = '0;
    end else begin
      next_ptr_s = next_sum_s[ID_W-1:0];
    end
  end

  // Next-state and registered-output logic for the IDLE/LOAD/RUN/RESP sequence.
  always_comb begin
    state_d           = state_q;
    rr_ptr_d          = rr_ptr_q;
    cur_id_d          = cur_id_q;
    res_id_d          = res_id_q;
    feat_buf_d        = feat_buf_q;
    k_feature_d       = k_feature_q;
    res_data_d        = res_data_q;
    k_feature_valid_d = 1'b0;
    res_valid_d       = res_valid_q;
    timeout_err_d     = 1'b0;
    err_count_d       = err_count_q;
    wd_d              = wd_q;
    case (state_q)
      S_IDLE: begin
        if (grant_any_s) begin
          feat_buf_d = grant_data_s;
          cur_id_d   = grant_id_s;
          rr_ptr_d   = next_ptr_s;
          state_d    = S_LOAD;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_LOAD: begin
        if (k_fetch) begin
          k_feature_valid_d = 1'b1;
          k_feature_d       = feat_buf_q;
          wd_d              = '0;
          state_d           = S_RUN;
        end else begin
          state_d = S_LOAD;
        end
      end
      S_RUN: begin
        wd_d = wd_q + {{(WD_W-1){1'b0}}, 1'b1};
        // A result arriving on the expiry cycle takes priority over the timeout.
        if (k_result_valid) begin
          res_data_d  = k_result;
          res_id_d    = cur_id_q;
          res_valid_d = 1'b1;
          state_d     = S_RESP;
        end else if (wd_q == WD_W'(TIMEOUT - 1)) begin
          timeout_err_d = 1'b1;
          err_count_d   = sat_inc(err_count_q);
          state_d       = S_IDLE;
        end else begin
          state_d = S_RUN;
        end
      end
      S_RESP: begin
        if (res_ready) begin
          res_valid_d = 1'b0;
          state_d     = S_IDLE;
        end else begin
          state_d = S_RESP;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    if (k_result_valid && (state_q != S_RUN)) begin
      err_count_d = sat_inc(err_count_q);
    end else begin
      err_count_d = err_count_d;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q           <= S_IDLE;
      rr_ptr_q          <= '0;
      cur_id_q          <= '0;
      res_id_q          <= '0;
      feat_buf_q        <= '0;
      k_feature_q       <= '0;
      res_data_q        <= '0;
      k_feature_valid_q <= 1'b0;
      res_valid_q       <= 1'b0;
      timeout_err_q     <= 1'b0;
      err_count_q       <= 8'd0;
      wd_q              <= '0;
    end else begin
      state_q           <= state_d;
      rr_ptr_q          <= rr_ptr_d;
      cur_id_q          <= cur_id_d;
      res_id_q          <= res_id_d;
      feat_buf_q        <= feat_buf_d;
      k_feature_q       <= k_feature_d;
      res_data_q        <= res_data_d;
      k_feature_valid_q <= k_feature_valid_d;
      res_valid_q       <= res_valid_d;
      timeout_err_q     <= timeout_err_d;
      err_count_q       <= err_count_d;
      wd_q              <= wd_d;
    end
  end

  // The grant strobe is gated by rst so it reads 0 while reset is held.
  assign req_ready       = (state_q == S_IDLE && !rst) ? grant_s : '0;
  assign busy            = (state_q != S_IDLE);
  assign k_feature_valid = k_feature_valid_q;
  assign k_feature       = k_feature_q;
  assign res_valid       = res_valid_q;
  assign res_data        = res_data_q;
  assign res_id          = res_id_q;
  assign timeout_err     = timeout_err_q;
  assign err_count       = err_count_q;

endmodule

// File: tb/tb_vpe_feature_arbiter.sv
// Self-checking bench for vpe_feature_arbiter: randomized transactions against a round-robin reference model.
module tb_vpe_feature_arbiter;
  localparam int NR = 4;
  localparam int DW = 256;
  localparam int TO = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [NR-1:0] req_valid = '0;
  logic [NR*DW-1:0] req_data = '0;
  logic [NR-1:0] req_ready;
  logic          k_fetch = 1'b0;
  logic          k_feature_valid;
  logic [DW-1:0] k_feature;
  logic          k_result_valid = 1'b0;
  logic [DW-1:0] k_result = '0;
  logic          res_valid;
  logic          res_ready = 1'b0;
  logic [DW-1:0] res_data;
  logic [1:0]    res_id;
  logic          busy;
  logic          timeout_err;
  logic [7:0]    err_count;

  int total = 0;
  int bad   = 0;
  int m_ptr = 0;
  int m_err = 0;

  vpe_feature_arbiter #(.NUM_REQ(NR), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
    .k_fetch(k_fetch), .k_feature_valid(k_feature_valid), .k_feature(k_feature),
    .k_result_valid(k_result_valid), .k_result(k_result), .res_valid(res_valid),
    .res_ready(res_ready), .res_data(res_data), .res_id(res_id), .busy(busy),
    .timeout_err(timeout_err), .err_count(err_count)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] rand256();
    logic [DW-1:0] v;
    for (int i = 0; i < DW/32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  // Reference: first requester at or after the pointer, wrapping around.
  function automatic int model_pick(input logic [NR-1:0] v);
    for (int k = 0; k < NR; k++) begin
      if (v[(m_ptr + k) % NR]) return (m_ptr + k) % NR;
    end
    return -1;
  endfunction

  task automatic do_txn(input logic [NR-1:0] valids, input int fd, input int rd, input int bd,
                        input bit keep_valid, input bit use_fixed, input logic [DW-1:0] ffeat,
                        input logic [DW-1:0] fres, output logic [NR-1:0] obs_ready);
    int g;
    logic [NR-1:0] exp_oh;
    logic [DW-1:0] slot [NR];
    logic [DW-1:0] exp_feat, exp_res;
    g = model_pick(valids);
    for (int i = 0; i < NR; i++) begin
      slot[i] = use_fixed ? ffeat : rand256();
      req_data[i*DW +: DW] = slot[i];
    end
    exp_oh = '0;
    exp_oh[g] = 1'b1;
    exp_feat = slot[g];
    exp_res = use_fixed ? fres : rand256();
    req_valid = valids;
    #1;
    obs_ready = req_ready;
    total++; if (req_ready !== exp_oh) begin bad++; $display("FAIL grant got=%b exp=%b", req_ready, exp_oh); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL idle_busy got=%b exp=0", busy); end
    m_ptr = (g + 1) % NR;
    @(negedge clk);
    if (!keep_valid) req_valid = '0;
    #1;
    total++; if (busy !== 1'b1 || req_ready !== '0) begin bad++; $display("FAIL load_state busy=%b ready=%b exp busy=1 ready=0", busy, req_ready); end
    repeat (fd) begin
      @(negedge clk);
      total++; if (k_feature_valid !== 1'b0) begin bad++; $display("FAIL early_kfv got=%b exp=0", k_feature_valid); end
    end
    k_fetch = 1'b1;
    @(negedge clk);
    k_fetch = 1'b0;
    total++; if (k_feature_valid !== 1'b1) begin bad++; $display("FAIL kfv got=%b exp=1", k_feature_valid); end
    total++; if (k_feature !== exp_feat) begin bad++; $display("FAIL kfeat got=%h exp=%h", k_feature, exp_feat); end
    repeat (rd) begin
      @(negedge clk);
      total++; if (k_feature_valid !== 1'b0 || res_valid !== 1'b0 || timeout_err !== 1'b0 || k_feature !== exp_feat)
        begin bad++; $display("FAIL run_idle kfv=%b rv=%b te=%b exp 0,0,0 feat held", k_feature_valid, res_valid, timeout_err); end
    end
    k_result = exp_res;
    k_result_valid = 1'b1;
    @(negedge clk);
    k_result_valid = 1'b0;
    k_result = rand256();
    total++; if (res_valid !== 1'b1 || timeout_err !== 1'b0) begin bad++; $display("FAIL resp rv=%b te=%b exp rv=1 te=0", res_valid, timeout_err); end
    total++; if (res_data !== exp_res) begin bad++; $display("FAIL res_data got=%h exp=%h", res_data, exp_res); end
    total++; if (res_id !== 2'(g)) begin bad++; $display("FAIL res_id got=%0d exp=%0d", res_id, g); end
    total++; if (err_count !== 8'(m_err)) begin bad++; $display("FAIL err_hold got=%0d exp=%0d", err_count, m_err); end
    repeat (bd) begin
      res_ready = 1'b0;
      @(negedge clk);
      #1;
      total++; if (res_valid !== 1'b1 || res_data !== exp_res || res_id !== 2'(g) || req_ready !== '0)
        begin bad++; $display("FAIL backpressure rv=%b id=%0d ready=%b exp rv=1 id=%0d ready=0", res_valid, res_id, req_ready, g); end
    end
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    total++; if (res_valid !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL resp_done rv=%b busy=%b exp 0,0", res_valid, busy); end
  endtask

  task automatic test_reset();
    #1;
    total++; if ({req_ready, k_feature_valid, res_valid, busy, timeout_err} !== 8'h00 || k_feature !== '0 ||
                 res_data !== '0 || res_id !== 2'd0 || err_count !== 8'd0)
      begin bad++; $display("FAIL reset_vals ready=%b kfv=%b rv=%b busy=%b err=%0d exp all 0", req_ready, k_feature_valid, res_valid, busy, err_count); end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    m_ptr = 0;
    m_err = 0;
  endtask

  task automatic test_fairness();
    int ord [5] = '{0, 1, 2, 3, 0};
    logic [NR-1:0] obs;
    logic [NR-1:0] want;
    for (int k = 0; k < 5; k++) begin
      do_txn(4'b1111, 0, 0, 0, 1'b1, 1'b0, '0, '0, obs);
      want = '0;
      want[ord[k]] = 1'b1;
      total++; if (obs !== want) begin bad++; $display("FAIL rr_order step=%0d got=%b exp=%b", k, obs, want); end
    end
    req_valid = '0;
  endtask

  task automatic test_single();
    logic [NR-1:0] obs;
    logic [DW-1:0] feat;
    logic [DW-1:0] res;
    feat = {32{8'hA5}};
    res = '0;
    res[15:0] = 16'h1234;
    do_txn(4'b0100, 0, 10, 0, 1'b0, 1'b1, feat, res, obs);
    total++; if (obs !== 4'b0100) begin bad++; $display("FAIL single_grant got=%b exp=0100", obs); end
  endtask

  task automatic test_backpressure();
    logic [NR-1:0] obs;
    do_txn(4'b1011, 1, 3, 20, 1'b1, 1'b0, '0, '0, obs);
    do_txn(4'b1011, 0, 0, 0, 1'b0, 1'b0, '0, '0, obs);
  endtask

  task automatic test_watchdog();
    int g;
    logic [NR-1:0] exp_oh;
    logic [NR-1:0] obs;
    g = model_pick(4'b0011);
    exp_oh = '0;
    exp_oh[g] = 1'b1;
    req_valid = 4'b0011;
    #1;
    total++; if (req_ready !== exp_oh) begin bad++; $display("FAIL wd_grant got=%b exp=%b", req_ready, exp_oh); end
    m_ptr = (g + 1) % NR;
    @(negedge clk);
    req_valid = '0;
    k_fetch = 1'b1;
    @(negedge clk);
    k_fetch = 1'b0;
    for (int k = 0; k < TO; k++) begin
      total++; if (timeout_err !== 1'b0 || res_valid !== 1'b0 || busy !== 1'b1)
        begin bad++; $display("FAIL wd_early cyc=%0d te=%b rv=%b busy=%b exp 0,0,1", k, timeout_err, res_valid, busy); end
      @(negedge clk);
    end
    m_err++;
    total++; if (timeout_err !== 1'b1) begin bad++; $display("FAIL wd_pulse got=%b exp=1", timeout_err); end
    total++; if (err_count !== 8'(m_err)) begin bad++; $display("FAIL wd_err got=%0d exp=%0d", err_count, m_err); end
    total++; if (busy !== 1'b0 || res_valid !== 1'b0) begin bad++; $display("FAIL wd_idle busy=%b rv=%b exp 0,0", busy, res_valid); end
    @(negedge clk);
    total++; if (timeout_err !== 1'b0) begin bad++; $display("FAIL wd_once got=%b exp=0", timeout_err); end
    do_txn(4'b0101, 0, 2, 0, 1'b0, 1'b0, '0, '0, obs);
  endtask

  task automatic test_spurious_race();
    logic [NR-1:0] obs;
    req_valid = '0;
    k_result_valid = 1'b1;
    k_result = rand256();
    @(negedge clk);
    k_result_valid = 1'b0;
    m_err++;
    total++; if (err_count !== 8'(m_err) || res_valid !== 1'b0 || busy !== 1'b0)
      begin bad++; $display("FAIL spurious err=%0d rv=%b busy=%b exp err=%0d rv=0 busy=0", err_count, res_valid, busy, m_err); end
    do_txn(4'b1000, 0, TO - 1, 1, 1'b0, 1'b0, '0, '0, obs);
    total++; if (err_count !== 8'(m_err)) begin bad++; $display("FAIL race_err got=%0d exp=%0d", err_count, m_err); end
  endtask

  task automatic test_random();
    logic [NR-1:0] obs;
    logic [NR-1:0] v;
    for (int n = 0; n < 10; n++) begin
      v = 4'($urandom_range(1, 15));
      do_txn(v, $urandom_range(0, 3), $urandom_range(0, TO - 2), $urandom_range(0, 3),
             1'($urandom_range(0, 1)), 1'b0, '0, '0, obs);
    end
  endtask

  task automatic test_reset_mid_run();
    logic [NR-1:0] obs;
    req_valid = 4'b0110;
    @(negedge clk);
    req_valid = 4'b1111;
    k_fetch = 1'b1;
    @(negedge clk);
    k_fetch = 1'b0;
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    total++; if ({req_ready, k_feature_valid, res_valid, busy, timeout_err} !== 8'h00 || k_feature !== '0 ||
                 res_data !== '0 || res_id !== 2'd0 || err_count !== 8'd0)
      begin bad++; $display("FAIL midrun_reset ready=%b busy=%b kfeat0=%b err=%0d exp all 0", req_ready, busy, k_feature == '0, err_count); end
    @(negedge clk);
    rst = 1'b0;
    m_ptr = 0;
    m_err = 0;
    do_txn(4'b1111, 0, 1, 0, 1'b0, 1'b0, '0, '0, obs);
    total++; if (obs !== 4'b0001) begin bad++; $display("FAIL post_reset_grant got=%b exp=0001", obs); end
  endtask

  initial begin
    test_reset();
    test_fairness();
    test_single();
    test_backpressure();
    test_watchdog();
    test_spurious_race();
    test_random();
    test_reset_mid_run();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/vpe_feature_arbiter.md
# vpe_feature_arbiter

Round-robin scheduler that shares one VPE inference kernel between several packet-feature requesters. It accepts one 256-bit feature vector at a time, answers the kernel's feature-fetch handshake, waits for the kernel's result and returns that result tagged with the originating requester ID. It sits between the per-port feature extractors and the kernel's `fetch_pkt_feature` / `pkt_feature_valid` / `o_data_valid` interface. A watchdog recovers from a kernel that never answers.

## Interface
- `NUM_REQ`, 4: number of requesters (2..8).
- `DATA_W`, 256: feature and result width.
- `TIMEOUT`, 4096: maximum cycles in RUN before the request is abandoned.
- `ID_W`, $clog2(NUM_REQ): requester-ID width (derived).
- `clk`  in  1  clock; all logic on the rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `req_valid`  in  NUM_REQ  per-requester feature valid.
- `req_data`  in  NUM_REQ*DATA_W  requester i occupies `[i*DATA_W +: DATA_W]`.
- `req_ready`  out  NUM_REQ  one-hot accept strobe to the granted requester.
- `k_fetch`  in  1  kernel requests a feature (level).
- `k_feature_valid`  out  1  one-cycle feature strobe to the kernel.
- `k_feature`  out  DATA_W  feature to the kernel.
- `k_result_valid`  in  1  kernel result strobe.
- `k_result`  in  DATA_W  kernel result.
- `res_valid`  out  1  tagged result available.
- `res_ready`  in  1  downstream accepts the result.
- `res_data`  out  DATA_W  captured result.
- `res_id`  out  ID_W  requester that owns `res_data`.
- `busy`  out  1  high when the state is not IDLE.
- `timeout_err`  out  1  one-cycle pulse when the watchdog fires.
- `err_count`  out  8  saturating count of timeouts and spurious results.

## Operation
- FSM states: IDLE, LOAD, RUN, RESP.
- **IDLE:**
  - The grant is combinational round-robin. Search starts at `rr_ptr` and picks the first i with `req_valid[i]`.
  - `req_ready` equals the grant one-hot in IDLE and is 0 in all other states.
  - On handshake: capture the data into `feat_buf` and i into `cur_id`, set `rr_ptr <= (i+1) mod NUM_REQ`, go to LOAD.
- **LOAD:** when `k_fetch` is sampled high, register `k_feature_valid <= 1` and `k_feature <= feat_buf` for exactly one cycle, then go to RUN. `k_fetch` is ignored in every other state.
- **RUN:**
  - The watchdog counter clears on entry and increments each cycle.
  - On `k_result_valid`: capture `res_data <= k_result`, `res_id <= cur_id`, set `res_valid <= 1`, go to RESP.
  - If the counter reaches TIMEOUT-1 without a result: pulse `timeout_err`, increment `err_count`, drop the request, go to IDLE.
- **RESP:** `res_valid` holds until `res_ready`. On handshake, clear `res_valid` and go to IDLE.
- A `k_result_valid` outside RUN is discarded and increments `err_count`.
- `err_count` saturates at 255.
- `k_feature` and `res_data` keep their last value when not strobed.
- Only one inference is in flight at a time. No new request is accepted until RESP completes or the watchdog fires.

## Timing
- Reset value of every output is 0 (`req_ready`, `k_feature_valid`, `k_feature`, `res_valid`, `res_data`, `res_id`, `busy`, `timeout_err`, `err_count`). After reset the state is IDLE and `rr_ptr = 0`.
- Request accepted at cycle t → `busy` = 1 at t+1.
- `k_fetch` high at t+1 → `k_feature_valid` = 1 at t+2 only.
- `k_result_valid` at cycle r → `res_valid` = 1 at r+1.
- `res_ready` high at cycle s while `res_valid` = 1 → `res_valid` = 0 and `busy` = 0 at s+1. The next accept can occur at s+1.
- Simultaneous `k_result_valid` and watchdog expiry: the result wins and no timeout is flagged.
- `res_ready` while `res_valid` = 0 is ignored.
- Reset mid-operation: all state clears, the in-flight request is lost and no response is issued. The kernel must be reset in the same cycle.
- Watchdog counter is `$clog2(TIMEOUT)+1` bits. Expiry happens exactly TIMEOUT cycles after RUN entry.

## Test plan
- **Single request:** `req_valid = 4'b0100`, data `0xA5…`; `k_fetch` high 1 cycle after accept; `k_result_valid` 10 cycles later with `0x1234`.
  → `req_ready = 4'b0100` for one cycle; `k_feature = 0xA5…` strobed once; `res_data = 0x1234`, `res_id = 2`.
- **Round-robin fairness:** all four `req_valid` held high; kernel answers each inference immediately; `res_ready` tied high.
  → grant order 0, 1, 2, 3, 0.
  → After granting 3, the next grant is 0 even though 1 is still requesting.
- **Backpressure:** `res_ready` held low for 20 cycles.
  → `res_valid`, `res_data` and `res_id` stay stable; `req_ready` stays 0 throughout.
  → Accept resumes the cycle after `res_ready` is asserted.
- **Watchdog:** `TIMEOUT = 16`; no `k_result_valid`.
  → `timeout_err` pulses exactly 16 cycles after RUN entry; `err_count = 1`; `res_valid` never asserts; the next request is granted.
- **Spurious result and race:** `k_result_valid` while IDLE → `err_count` increments, no response. `k_result_valid` on the same cycle as watchdog expiry → result delivered, no `timeout_err`.
- **Reset mid-RUN:** assert `rst` asynchronously → all outputs 0 immediately; after release, `rr_ptr = 0` and requester 0 is granted first.
